// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared types and constants for the LCD write sequencer.
package lcd_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_EN, S_W_HOLD, S_P_SETUP, S_P_EN, S_P_HOLD
    } state_t;
    localparam logic [1:0] ADDR_CMD   = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd1;
    localparam logic [1:0] ADDR_STAT  = 2'd2;
    localparam logic [1:0] ADDR_LEVEL = 2'd3;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_TMO   = 4;
    localparam int ENTRY_W  = 9;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: show-ahead FIFO of {RS, byte} entries with occupancy count.
module lcd_cmd_fifo
    import lcd_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: Avalon-MM slave replaying queued LCD bytes with timed strobes and busy polling.
module lcd_write_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int T_AS       = 3,
    parameter int T_PW       = 13,
    parameter int T_H        = 2,
    parameter int MAX_POLLS  = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [7:0] LCD_data_in
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = ((T_AS > T_PW ? T_AS : T_PW) > T_H) ? (T_AS > T_PW ? T_AS : T_PW) : T_H;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(MAX_POLLS + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      polls;
    logic               busy_q, ovf, tmo;
    logic               push, pop, full, empty, host_push, ovf_set, clr, done;
    logic [ENTRY_W-1:0] dout;
    logic [AW:0]        count;
    logic [7:0]         status;
    logic               unused_in;

    assign unused_in = ^LCD_data_in[6:0];
    assign host_push = write && (address == ADDR_CMD || address == ADDR_DATA);
    assign pop       = state == S_IDLE && !empty;
    assign push      = host_push && (!full || pop);
    assign ovf_set   = host_push && full && !pop;
    assign clr       = write && address == ADDR_STAT && writedata[0];
    assign done      = cnt == '0;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
        .din({address[0], writedata}), .dout(dout),
        .full(full), .empty(empty), .count(count)
    );

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf;
        status[ST_BUSY]  = state != S_IDLE;
        status[ST_TMO]   = tmo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf      <= 1'b0;
            readdata <= '0;
        end else begin
            ovf <= ovf_set | (ovf & ~clr);
            if (read) readdata <= address == ADDR_STAT ? status : address == ADDR_LEVEL ? 8'(count) : '0;
        end
    end

    // Every state but IDLE waits for the shared counter to expire; the case only acts on expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            polls        <= '0;
            busy_q       <= 1'b0;
            tmo          <= 1'b0;
            LCD_E        <= 1'b0;
            LCD_RS       <= 1'b0;
            LCD_RW       <= 1'b0;
            LCD_data_out <= '0;
            LCD_data_oe  <= 1'b0;
        end else begin
            if (clr) tmo <= 1'b0;
            if (!done) cnt <= cnt - 1'b1;
            case (state)
                S_IDLE: if (!empty) begin
                    {LCD_RS, LCD_data_out} <= dout;
                    LCD_RW      <= 1'b0;
                    LCD_data_oe <= 1'b1;
                    cnt         <= CW'(T_AS - 1);
                    state       <= S_W_SETUP;
                end
                S_W_SETUP: if (done) begin
                    LCD_E <= 1'b1;
                    cnt   <= CW'(T_PW - 1);
                    state <= S_W_EN;
                end
                S_W_EN: if (done) begin
                    LCD_E <= 1'b0;
                    cnt   <= CW'(T_H - 1);
                    state <= S_W_HOLD;
                end
                S_W_HOLD: if (done) begin
                    LCD_RS      <= 1'b0;
                    LCD_RW      <= 1'b1;
                    LCD_data_oe <= 1'b0;
                    polls       <= '0;
                    cnt         <= CW'(T_AS - 1);
                    state       <= S_P_SETUP;
                end
                S_P_SETUP: if (done) begin
                    LCD_E <= 1'b1;
                    cnt   <= CW'(T_PW - 1);
                    state <= S_P_EN;
                end
                S_P_EN: if (done) begin
                    LCD_E  <= 1'b0;
                    busy_q <= LCD_data_in[7];
                    cnt    <= CW'(T_H - 1);
                    state  <= S_P_HOLD;
                end
                S_P_HOLD: if (done) begin
                    if (!busy_q) begin
                        state <= S_IDLE;
                    end else if (polls < PW'(MAX_POLLS)) begin
                        polls <= polls + 1'b1;
                        cnt   <= CW'(T_AS - 1);
                        state <= S_P_SETUP;
                    end else begin
                        tmo   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: directed scenarios for the LCD write sequencer (MAX_POLLS=4).
module tb_lcd_write_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       LCD_E, LCD_RS, LCD_RW, LCD_data_oe;
    logic [7:0] LCD_data_out;
    logic [7:0] LCD_data_in = 8'h00;
    int checks = 0;
    int failures = 0;
    logic te [200];
    logic trs [200];
    logic trw [200];
    logic toe [200];
    logic [7:0] td [200];

    always #5 clk = ~clk;

    lcd_write_sequencer #(.MAX_POLLS(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
        .LCD_data_in(LCD_data_in)
    );

    // Byte timeline from the first W_SETUP cycle: 3 setup, 13 enable, 2 hold, repeated per poll.
    function automatic logic exp_e(input int i);
        return (i % 18) >= 3 && (i % 18) <= 15;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    // Records pins each cycle; busy is reported by the first nb polls only.
    task automatic capture(input int n, input int nb);
        for (int i = 0; i < n; i++) begin
            LCD_data_in = (i >= 18 && i < 18 + 18 * nb) ? 8'h80 : 8'h00;
            te[i] = LCD_E; trs[i] = LCD_RS; trw[i] = LCD_RW; toe[i] = LCD_data_oe; td[i] = LCD_data_out;
            tick();
        end
    endtask

    task automatic drain(input int limit, output logic hit40);
        logic [7:0] s;
        logic idle;
        hit40 = 1'b0; idle = 1'b0; s = 8'h00;
        for (int i = 0; i < limit && !idle; i++) begin
            rd(2'd2, s);
            if (LCD_data_out == 8'h40) hit40 = 1'b1;
            idle = s[0] && !s[3];
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL drain: status=%h after %0d reads, want empty and idle", s, limit);
        end
    endtask

    task automatic test_reset;
        logic [7:0] s;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, readdata} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, readdata});
        end
        reset_n = 1'b1;
        tick();
        rd(2'd2, s);
        checks++;
        if (s !== 8'h01) begin failures++; $display("FAIL reset_status: got %h want 01", s); end
        rd(2'd3, s);
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL reset_level: got %h want 00", s); end
    endtask

    task automatic test_cmd_write;
        logic [3:0] g, x;
        logic h;
        LCD_data_in = 8'h00;
        wr(2'd0, 8'h38);
        wr(2'd0, 8'h0C);
        capture(40, 0);
        for (int i = 0; i < 36; i++) begin
            g = {te[i], trs[i], trw[i], toe[i]};
            x = {exp_e(i), 1'b0, i >= 18, i < 18};
            checks++;
            if (g !== x) begin failures++; $display("FAIL cmd_pins[%0d]: E/RS/RW/OE got %b want %b", i, g, x); end
            if (i < 18) begin
                checks++;
                if (td[i] !== 8'h38) begin failures++; $display("FAIL cmd_data[%0d]: got %h want 38", i, td[i]); end
            end
        end
        checks++;
        if ({te[36], toe[36]} !== 2'b00) begin
            failures++; $display("FAIL cmd_idle: E/OE got %b want 00", {te[36], toe[36]});
        end
        checks++;
        if ({toe[37], trw[37], trs[37], td[37]} !== {3'b100, 8'h0C}) begin
            failures++; $display("FAIL cmd_next: got %h want %h", {toe[37], trw[37], trs[37], td[37]}, {3'b100, 8'h0C});
        end
        drain(500, h);
    endtask

    task automatic test_data_polls;
        logic [3:0] g, x;
        int rises;
        logic h;
        wr(2'd1, 8'h41);
        wr(2'd1, 8'h42);
        capture(80, 2);
        rises = 0;
        for (int i = 0; i < 72; i++) begin
            g = {te[i], trs[i], trw[i], toe[i]};
            x = {exp_e(i), i < 18, i >= 18, i < 18};
            checks++;
            if (g !== x) begin failures++; $display("FAIL data_pins[%0d]: E/RS/RW/OE got %b want %b", i, g, x); end
        end
        for (int i = 0; i < 73; i++) if (te[i] && (i == 0 || !te[i-1])) rises++;
        checks++;
        if (rises !== 4) begin failures++; $display("FAIL data_strobes: got %0d E pulses want 4", rises); end
        checks++;
        if ({te[72], toe[72], td[72]} !== {2'b00, 8'h41}) begin
            failures++; $display("FAIL data_idle: got %h want %h", {te[72], toe[72], td[72]}, {2'b00, 8'h41});
        end
        checks++;
        if ({toe[73], trw[73], trs[73], td[73]} !== {3'b101, 8'h42}) begin
            failures++; $display("FAIL data_next: got %h want %h", {toe[73], trw[73], trs[73], td[73]}, {3'b101, 8'h42});
        end
        drain(500, h);
    endtask

    task automatic test_overflow_burst;
        logic [7:0] s;
        logic h;
        LCD_data_in = 8'h80;
        wr(2'd0, 8'h20);
        tick();
        for (int k = 0; k < 17; k++) wr(2'd1, 8'h30 + 8'(k));
        rd(2'd3, s);
        checks++;
        if (s !== 8'd16) begin failures++; $display("FAIL burst_level: got %0d want 16", s); end
        rd(2'd2, s);
        checks++;
        if (s !== 8'h0E) begin failures++; $display("FAIL burst_status: got %h want 0e", s); end
        LCD_data_in = 8'h00;
        drain(2000, h);
        checks++;
        if (h !== 1'b0) begin failures++; $display("FAIL burst_dropped: byte 40 seen=%b want 0", h); end
    endtask

    task automatic test_timeout;
        logic [3:0] g, x;
        logic [7:0] s;
        int rises;
        logic h;
        wr(2'd1, 8'h55);
        wr(2'd1, 8'h66);
        capture(112, 100);
        rises = 0;
        for (int i = 0; i < 108; i++) begin
            g = {te[i], trs[i], trw[i], toe[i]};
            x = {exp_e(i), i < 18, i >= 18, i < 18};
            checks++;
            if (g !== x) begin failures++; $display("FAIL tmo_pins[%0d]: E/RS/RW/OE got %b want %b", i, g, x); end
        end
        for (int i = 0; i < 109; i++) if (te[i] && (i == 0 || !te[i-1])) rises++;
        checks++;
        if (rises !== 6) begin failures++; $display("FAIL tmo_strobes: got %0d E pulses want 6", rises); end
        checks++;
        if ({te[108], toe[108]} !== 2'b00) begin
            failures++; $display("FAIL tmo_idle: E/OE got %b want 00", {te[108], toe[108]});
        end
        checks++;
        if ({toe[109], trw[109], trs[109], td[109]} !== {3'b101, 8'h66}) begin
            failures++; $display("FAIL tmo_next: got %h want %h", {toe[109], trw[109], trs[109], td[109]}, {3'b101, 8'h66});
        end
        LCD_data_in = 8'h00;
        rd(2'd2, s);
        checks++;
        if (s[4] !== 1'b1) begin failures++; $display("FAIL tmo_flag: status %h want bit4 set", s); end
        drain(500, h);
    endtask

    task automatic test_reset_mid;
        logic [7:0] s;
        LCD_data_in = 8'h00;
        wr(2'd0, 8'h01);
        wr(2'd0, 8'h02);
        wr(2'd0, 8'h03);
        for (int i = 0; i < 50 && !LCD_E; i++) tick();
        repeat (5) tick();
        checks++;
        if ({LCD_E, LCD_RW} !== 2'b10) begin failures++; $display("FAIL rst_mid_pre: E/RW got %b want 10", {LCD_E, LCD_RW}); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, readdata} !== 20'h0) begin
            failures++;
            $display("FAIL rst_mid_pins: got %h want 0", {LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, readdata});
        end
        tick();
        reset_n = 1'b1;
        tick();
        rd(2'd3, s);
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL rst_mid_level: got %h want 00", s); end
        rd(2'd2, s);
        checks++;
        if (s !== 8'h01) begin failures++; $display("FAIL rst_mid_status: got %h want 01", s); end
    endtask

    task automatic test_status_clear;
        logic [7:0] s;
        logic h;
        LCD_data_in = 8'h80;
        wr(2'd0, 8'h20);
        tick();
        for (int k = 0; k < 17; k++) wr(2'd1, 8'h30 + 8'(k));
        repeat (110) tick();
        LCD_data_in = 8'h00;
        drain(3000, h);
        rd(2'd2, s);
        checks++;
        if (s !== 8'h15) begin failures++; $display("FAIL clr_before: got %h want 15", s); end
        wr(2'd2, 8'h00);
        rd(2'd2, s);
        checks++;
        if (s !== 8'h15) begin failures++; $display("FAIL clr_bit0_zero: got %h want 15", s); end
        wr(2'd3, 8'h55);
        rd(2'd3, s);
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL level_write_ignored: got %h want 00", s); end
        wr(2'd2, 8'h01);
        rd(2'd2, s);
        checks++;
        if (s !== 8'h01) begin failures++; $display("FAIL clr_after: got %h want 01", s); end
    endtask

    initial begin
        test_reset();
        test_cmd_write();
        test_data_polls();
        test_overflow_burst();
        test_timeout();
        test_reset_mid();
        test_status_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
